// File: rtl/store_merge_unit_if.sv
// store_merge_unit_if: request/response and memory-port bundle for the store merge unit
interface store_merge_unit_if;
  logic        start;
  logic [2:0]  select;
  logic [63:0] addr;
  logic [63:0] st_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] mem_addr;
  logic        mem_rd;
  logic [63:0] mem_rdata;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  modport master (
    output start, select, addr, st_data, mem_rdata,
    input  busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
  );
  modport slave (
    input  start, select, addr, st_data, mem_rdata,
    output busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/store_merge_unit.sv
// store_merge_unit: read-modify-write merge of sb/sh/sw/sd stores into 64-bit memory
module store_merge_unit #(
  parameter int MEM_LAT = 1
) (
  input logic             clk,
  input logic             reset_n,
  store_merge_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, MERGE, WRITE, DONE} state_t;
  state_t      state;
  logic [1:0]  sel_q;
  logic [2:0]  off_q;
  logic [31:0] data_q;
  logic [2:0]  cnt;
  logic        bad;
  logic [63:0] mask;
  logic [63:0] merged;
  // legality of the incoming request and the byte-lane merge of old data with the latched store
  always_comb begin
    bad = bus.select[2] |
          (bus.select[1:0] == 2'b01 ? bus.addr[0] :
           bus.select[1:0] == 2'b10 ? |bus.addr[1:0] :
           bus.select[1:0] == 2'b11 ? |bus.addr[2:0] : 1'b0);
    mask = sel_q == 2'b00 ? 64'h0000_0000_0000_00ff :
           sel_q == 2'b01 ? 64'h0000_0000_0000_ffff : 64'h0000_0000_ffff_ffff;
    merged = (bus.mem_rdata & ~(mask << {off_q, 3'b000})) |
             (({32'h0, data_q} & mask) << {off_q, 3'b000});
  end
  // transaction FSM with registered handshake and memory-port outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      sel_q         <= '0;
      off_q         <= '0;
      data_q        <= '0;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sel_q        <= bus.select[1:0];
          off_q        <= bus.addr[2:0];
          data_q       <= bus.st_data[31:0];
          bus.mem_addr <= {bus.addr[63:3], 3'b000};
          bus.busy     <= 1'b1;
          if (bad) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.err  <= 1'b1;
          end else if (bus.select[1:0] == 2'b11) begin
            state         <= WRITE;
            bus.mem_wdata <= bus.st_data;
            bus.mem_wr    <= 1'b1;
          end else begin
            state      <= RD_WAIT;
            bus.mem_rd <= 1'b1;
            cnt        <= 3'(MEM_LAT - 1);
          end
        end
        RD_WAIT: begin
          state      <= cnt == 3'd0 ? MERGE : RD_WAIT;
          bus.mem_rd <= cnt != 3'd0;
          cnt        <= cnt == 3'd0 ? cnt : cnt - 3'd1;
        end
        MERGE: begin
          state         <= WRITE;
          bus.mem_wdata <= merged;
          bus.mem_wr    <= 1'b1;
        end
        WRITE: begin
          state      <= DONE;
          bus.mem_wr <= 1'b0;
          bus.done   <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: vector table, random model comparison and corner sequences for store_merge_unit
module tb_store_merge_unit;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  store_merge_unit_if bus();
  store_merge_unit #(.MEM_LAT(LAT)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic [2:0]  sel;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] old;
    logic        err;
    logic [63:0] wdata;
    int          lat;
  } vec_t;
  vec_t tbl[10];
  int compared = 0;
  int mismatched = 0;
  logic [63:0] mem [logic [60:0]];
  logic [7:0]  rd_d;
  logic [63:0] rdq;
  int rd_n, wr_n, done_n, err_bad;
  logic [63:0] wdata_c, waddr_c;
  int lat_g;
  logic err_g, busy_g;
  function automatic logic [63:0] peek(input logic [60:0] i);
    return mem.exists(i) ? mem[i] : {i[31:0], ~i[31:0]};
  endfunction
  function automatic logic [63:0] merge_ref(input logic [63:0] old, d, input int n, off);
    logic [63:0] r = old;
    for (int k = 0; k < n; k++) r[8*(off+k) +: 8] = d[8*k +: 8];
    return r;
  endfunction
  // memory with LAT-cycle read latency; data outside the valid window is junk
  always @(posedge clk or negedge reset_n)
    if (!reset_n) rd_d <= '0;
    else rd_d <= {rd_d[6:0], bus.mem_rd};
  always @(posedge clk) rdq <= peek(bus.mem_addr[63:3]);
  assign bus.mem_rdata = rd_d[LAT-1] ? rdq : 64'ha5a5_5a5a_dead_beef;
  // monitor and memory write port, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_rd) rd_n++;
    if (bus.mem_wr) begin
      wr_n++;
      wdata_c = bus.mem_wdata;
      waddr_c = bus.mem_addr;
      mem[bus.mem_addr[63:3]] = bus.mem_wdata;
    end
    if (bus.done) done_n++;
    if (bus.err && !bus.done) err_bad++;
  end
  task automatic chk(input string n, input logic [63:0] act, exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic run(input logic [2:0] s, input logic [63:0] a, d);
    @(posedge clk); #1;
    rd_n = 0; wr_n = 0; done_n = 0;
    bus.start = 1'b1; bus.select = s; bus.addr = a; bus.st_data = d;
    lat_g = 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat_g = 2;
    while (!bus.done && lat_g < 40) begin
      @(posedge clk); #1;
      lat_g++;
    end
    err_g = bus.err;
    busy_g = bus.busy;
    @(negedge clk); #1;
  endtask
  task automatic txn(input string tag, input logic [2:0] s, input logic [63:0] a, d);
    int n = 1 << s[1:0];
    logic e_x = s[2] || (int'(a[2:0]) % n != 0);
    logic [63:0] old = peek(a[63:3]);
    int lat_x = e_x ? 2 : (s[1:0] == 2'b11 ? 3 : LAT + 4);
    int rd_x = (e_x || s[1:0] == 2'b11) ? 0 : LAT;
    run(s, a, d);
    chk({tag, " latency"}, 64'(lat_g), 64'(lat_x));
    chk({tag, " err"}, 64'(err_g), 64'(e_x));
    chk({tag, " busy at done"}, 64'(busy_g), 64'd1);
    chk({tag, " write count"}, 64'(wr_n), e_x ? 64'd0 : 64'd1);
    chk({tag, " read cycles"}, 64'(rd_n), 64'(rd_x));
    if (!e_x) begin
      chk({tag, " mem_addr"}, waddr_c, {a[63:3], 3'b000});
      chk({tag, " mem_wdata"}, wdata_c, merge_ref(old, d, n, int'(a[2:0])));
    end
  endtask
  initial begin
    bus.start = 1'b0; bus.select = '0; bus.addr = '0; bus.st_data = '0;
    err_bad = 0;
    tbl[0] = '{3'b011, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 64'h1122_3344_5566_7788, 3};
    tbl[1] = '{3'b000, 64'h13, 64'hab, 64'hffff_ffff_ffff_ffff, 1'b0, 64'hffff_ffff_abff_ffff, LAT + 4};
    tbl[2] = '{3'b001, 64'h0e, 64'hbeef, 64'h0, 1'b0, 64'hbeef_0000_0000_0000, 7};
    tbl[3] = '{3'b010, 64'h02, 64'h1234_5678, 64'h0, 1'b1, 64'h0, 2};
    tbl[4] = '{3'b101, 64'h20, 64'h55, 64'h0, 1'b1, 64'h0, 2};
    tbl[5] = '{3'b010, 64'h24, 64'hffff_ffff_cafe_f00d, 64'h0123_4567_89ab_cdef, 1'b0, 64'hcafe_f00d_89ab_cdef, LAT + 4};
    tbl[6] = '{3'b011, 64'h1b, 64'h1, 64'h0, 1'b1, 64'h0, 2};
    tbl[7] = '{3'b001, 64'h31, 64'h1, 64'h0, 1'b1, 64'h0, 2};
    tbl[8] = '{3'b000, 64'h47, 64'h1234, 64'h0, 1'b0, 64'h3400_0000_0000_0000, LAT + 4};
    tbl[9] = '{3'b111, 64'h40, 64'h9, 64'h0, 1'b1, 64'h0, 2};
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset err", 64'(bus.err), 64'd0);
    chk("reset mem_rd", 64'(bus.mem_rd), 64'd0);
    chk("reset mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("reset mem_addr", bus.mem_addr, 64'd0);
    chk("reset mem_wdata", bus.mem_wdata, 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem[tbl[i].addr[63:3]] = tbl[i].old;
      txn($sformatf("vec%0d", i), tbl[i].sel, tbl[i].addr, tbl[i].data);
      chk($sformatf("vec%0d table latency", i), 64'(lat_g), 64'(tbl[i].lat));
      chk($sformatf("vec%0d table err", i), 64'(err_g), 64'(tbl[i].err));
      if (!tbl[i].err) chk($sformatf("vec%0d table wdata", i), wdata_c, tbl[i].wdata);
    end
    for (int i = 0; i < 60; i++) begin
      logic [2:0] s = ($urandom % 4 == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      logic [63:0] a = 64'($urandom_range(0, 63)) | (($urandom % 5 == 0) ? 64'h8000_0000_0000_0000 : 64'h0);
      logic [63:0] d = {$urandom, $urandom};
      if ($urandom % 3 != 0) a = a & ~64'((1 << s[1:0]) - 1);
      txn($sformatf("rnd%0d", i), s, a, d);
    end
    @(posedge clk); #1;
    mem[61'h50 >> 3] = 64'h0;
    bus.start = 1'b1; bus.select = 3'b000; bus.addr = 64'h50; bus.st_data = 64'h77;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("rst-abort mem_rd before", 64'(bus.mem_rd), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst-abort mem_rd", 64'(bus.mem_rd), 64'd0);
    chk("rst-abort mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst-abort busy", 64'(bus.busy), 64'd0);
    chk("rst-abort mem_addr", bus.mem_addr, 64'd0);
    wr_n = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    chk("rst-abort no write", 64'(wr_n), 64'd0);
    chk("rst-abort old data kept", peek(61'h50 >> 3), 64'h0);
    txn("after-reset sb", 3'b000, 64'h51, 64'h66);
    @(posedge clk); #1;
    done_n = 0; wr_n = 0; rd_n = 0;
    bus.start = 1'b1; bus.select = 3'b011; bus.addr = 64'h80; bus.st_data = 64'h0bad_cafe_1234_5678;
    repeat (11) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("held-start sd dones", 64'(done_n), 64'd4);
    chk("held-start sd writes", 64'(wr_n), 64'd4);
    repeat (4) @(posedge clk);
    #1;
    chk("held-start sd idle busy", 64'(bus.busy), 64'd0);
    chk("held-start sd no extra", 64'(done_n), 64'd4);
    done_n = 0; wr_n = 0; rd_n = 0;
    bus.start = 1'b1; bus.select = 3'b000; bus.addr = 64'h89; bus.st_data = 64'h5a;
    repeat (2 * (LAT + 4) - 1) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("held-start sb dones", 64'(done_n), 64'd2);
    chk("held-start sb writes", 64'(wr_n), 64'd2);
    chk("held-start sb reads", 64'(rd_n), 64'(2 * LAT));
    repeat (4) @(posedge clk);
    #1;
    chk("held-start sb no extra", 64'(done_n), 64'd2);
    chk("err only with done", 64'(err_bad), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
